ctrl_pipe: RTL

Pipelined, parametrised successor to the single-cycle MIPS control decoder. Decodes opcode/funct/rt into a control bundle and carries that bundle through NUM_STAGES registered pipeline stages, each with a valid bit and a destination register. Detects load-use hazards, freezes on memory wait and accepts front-end flushes, producing one stall signal for the fetch/decode stages. Sits between instruction decode and the execute/memory/writeback datapath.

---
 rtl/ctrl_pkg.sv | 115 +++++++++++
 rtl/ctrl_decode.sv | 116 +++++++++++
 rtl/ctrl_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control path: opcode/funct
// constants, ALU op encodings (shared with ALUdec), reg_dst encodings and
// the control bundle layout. Optional feature macro: MULDIV_EN.
package ctrl_pkg;

  localparam int unsigned CTRL_W = 15;

  // Primary opcodes, instruction[31:26]
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes, instruction[5:0]
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    DST_RD  = 2'b00,
    DST_RT  = 2'b01,
    DST_R31 = 2'b10
  } reg_dst_e;

  // Packed MSB-first, so field positions match the F_* offsets below
  typedef struct packed {
    alu_op_e  alu_op;
    reg_dst_e reg_dst;
    logic     reg_we;
    logic     mem_to_reg;
    logic     mem_rd;
    logic     mem_wr;
    logic     sign_ext;
    logic     sel_imm;
    logic     sel_shamt;
    logic     jal_r;
    logic     is_branch;
  } ctrl_t;

  localparam int unsigned F_IS_BRANCH  = 0;
  localparam int unsigned F_JAL_R      = 1;
  localparam int unsigned F_SEL_SHAMT  = 2;
  localparam int unsigned F_SEL_IMM    = 3;
  localparam int unsigned F_SIGN_EXT   = 4;
  localparam int unsigned F_MEM_WR     = 5;
  localparam int unsigned F_MEM_RD     = 6;
  localparam int unsigned F_MEM_TO_REG = 7;
  localparam int unsigned F_REG_WE     = 8;
  localparam int unsigned F_REG_DST    = 9;
  localparam int unsigned F_ALU_OP     = 11;

  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn[5:2] == 4'b0110);
  endfunction

  function automatic logic is_mfhilo(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && ((fn == FN_MFHI) || (fn == FN_MFLO));
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational MIPS control decoder: opcode/funct to control bundle,
// destination register and source-usage flags. Optional feature macro:
// MULDIV_EN (adds MULT/MULTU/DIV/DIVU and MFHI/MFLO decode).
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  output logic [CTRL_W-1:0] ctrl,
  output logic [4:0]        dest,
  output logic              uses_rs,
  output logic              uses_rt
);

  ctrl_t      c;
  logic [4:0] dst_sel;

  // Decode bundle, then derive dest and suppress writes to $0
  always_comb begin
    c       = '0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    dst_sel = '0;
    dest    = '0;
    case (opcode)
      OP_RTYPE: begin
        uses_rt  = 1'b1;
        c.reg_dst = DST_RD;
        c.reg_we  = 1'b1;
        case (funct)
          FN_SLL:  begin c.alu_op = ALU_SLL; c.sel_shamt = 1'b1; uses_rs = 1'b0; end
          FN_SRL:  begin c.alu_op = ALU_SRL; c.sel_shamt = 1'b1; uses_rs = 1'b0; end
          FN_SRA:  begin c.alu_op = ALU_SRA; c.sel_shamt = 1'b1; uses_rs = 1'b0; end
          FN_SLLV: c.alu_op = ALU_SLL;
          FN_SRLV: c.alu_op = ALU_SRL;
          FN_SRAV: c.alu_op = ALU_SRA;
          FN_JR:   c.reg_we = 1'b0;
          FN_JALR: c.jal_r  = 1'b1;
          FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_XOR:  c.alu_op = ALU_XOR;
          FN_NOR:  c.alu_op = ALU_NOR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLTU: c.alu_op = ALU_SLTU;
`ifdef MULDIV_EN
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: c.reg_we = 1'b0;
          FN_MFHI, FN_MFLO: c.alu_op = ALU_ADD;
`endif
          default: c = '0;
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        c.reg_dst    = DST_RT;
        c.reg_we     = 1'b1;
        c.mem_rd     = 1'b1;
        c.mem_to_reg = 1'b1;
        c.sign_ext   = 1'b1;
        c.sel_imm    = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        uses_rt    = 1'b1;
        c.mem_wr   = 1'b1;
        c.sign_ext = 1'b1;
        c.sel_imm  = 1'b1;
      end
      OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        c.alu_op   = (opcode == OP_ADDIU) ? ALU_ADD :
                     (opcode == OP_SLTI)  ? ALU_SLT : ALU_SLTU;
        c.reg_dst  = DST_RT;
        c.reg_we   = 1'b1;
        c.sign_ext = 1'b1;
        c.sel_imm  = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        c.alu_op  = (opcode == OP_ANDI) ? ALU_AND :
                    (opcode == OP_ORI)  ? ALU_OR  :
                    (opcode == OP_XORI) ? ALU_XOR : ALU_LUI;
        c.reg_dst = DST_RT;
        c.reg_we  = 1'b1;
        c.sel_imm = 1'b1;
        uses_rs   = (opcode != OP_LUI);
      end
      OP_JAL: begin
        c.reg_dst = DST_R31;
        c.reg_we  = 1'b1;
        c.jal_r   = 1'b1;
        uses_rs   = 1'b0;
      end
      OP_J: uses_rs = 1'b0;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        c.alu_op    = ALU_SUB;
        c.is_branch = 1'b1;
        c.sign_ext  = 1'b1;
        c.sel_imm   = 1'b1;
        uses_rt     = (opcode == OP_BEQ) || (opcode == OP_BNE);
      end
      default: c = '0;
    endcase

    case (c.reg_dst)
      DST_RT:  dst_sel = rt;
      DST_R31: dst_sel = 5'd31;
      default: dst_sel = rd;
    endcase
    dest = c.reg_we ? dst_sel : 5'd0;
    if (dest == 5'd0)
      c.reg_we = 1'b0;
  end

  assign ctrl = c;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control path: decodes the instruction in decode and carries the
// control bundle, valid bit and destination register through NUM_STAGES
// registered stages. Generates stall_out for load-use hazards, memory wait
// and (with MULDIV_EN) mult/div busy hazards. Optional feature macro:
// MULDIV_EN.
module ctrl_pipe #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned CTRL_W     = ctrl_pkg::CTRL_W,
  parameter int unsigned MD_LATENCY = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [5:0]                   opcode,
  input  logic [5:0]                   funct,
  input  logic [4:0]                   rs,
  input  logic [4:0]                   rt,
  input  logic [4:0]                   rd,
  input  logic                         flush,
  input  logic                         mem_stall,
  output logic                         stall_out,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [NUM_STAGES*5-1:0]      stage_dest,
  output logic                         md_start
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic [4:0]        dec_dest;
  logic              dec_uses_rs;
  logic              dec_uses_rt;

  logic              valid_q [NUM_STAGES];
  logic [CTRL_W-1:0] ctrl_q  [NUM_STAGES];
  logic [4:0]        dest_q  [NUM_STAGES];

  logic load_use;
  logic md_hazard;
  logic bubble;

  ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .rt      (rt),
    .rd      (rd),
    .ctrl    (dec_ctrl),
    .dest    (dec_dest),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt)
  );

  // Load in execute whose result a decode-stage source needs
  always_comb begin
    load_use = in_valid & valid_q[0] & ctrl_q[0][ctrl_pkg::F_MEM_RD] &
               (dest_q[0] != 5'd0) &
               ((dec_uses_rs & (rs == dest_q[0])) |
                (dec_uses_rt & (rt == dest_q[0])));
    bubble    = flush | load_use | md_hazard;
    stall_out = mem_stall | load_use | md_hazard;
  end

`ifdef MULDIV_EN
  localparam int unsigned MD_CNT_W = $clog2(MD_LATENCY + 1);

  logic [MD_CNT_W-1:0] md_cnt;
  logic                md_start_q;
  logic                md_launch;

  // Busy hazard for HI/LO readers and back-to-back mult/div
  always_comb begin
    md_hazard = in_valid & (md_cnt != '0) &
                (ctrl_pkg::is_muldiv(opcode, funct) | ctrl_pkg::is_mfhilo(opcode, funct));
    md_launch = in_valid & ctrl_pkg::is_muldiv(opcode, funct) &
                ~flush & ~load_use & ~md_hazard;
  end

  // Busy counter and launch pulse; both freeze with the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      md_cnt     <= '0;
      md_start_q <= 1'b0;
    end else if (mem_stall) begin
      md_start_q <= 1'b0;
    end else begin
      md_start_q <= md_launch;
      if (md_launch)
        md_cnt <= MD_CNT_W'(MD_LATENCY);
      else if (md_cnt != '0)
        md_cnt <= md_cnt - MD_CNT_W'(1);
    end
  end

  assign md_start = md_start_q;
`else
  assign md_hazard = 1'b0;
  assign md_start  = 1'b0;
`endif

  // Stage registers: freeze on mem_stall, otherwise shift and load stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
        valid_q[i] <= 1'b0;
        ctrl_q[i]  <= '0;
        dest_q[i]  <= '0;
      end
    end else if (!mem_stall) begin
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        ctrl_q[i]  <= ctrl_q[i-1];
        dest_q[i]  <= dest_q[i-1];
      end
      if (bubble) begin
        valid_q[0] <= 1'b0;
        ctrl_q[0]  <= '0;
        dest_q[0]  <= '0;
      end else begin
        valid_q[0] <= in_valid;
        ctrl_q[0]  <= dec_ctrl;
        dest_q[0]  <= dec_dest;
      end
    end
  end

  // Flatten stage arrays onto the output buses, stage 0 in the LSBs
  always_comb begin
    stage_valid = '0;
    stage_ctrl  = '0;
    stage_dest  = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      stage_valid[i]                = valid_q[i];
      stage_ctrl[i*CTRL_W +: CTRL_W] = ctrl_q[i];
      stage_dest[i*5 +: 5]          = dest_q[i];
    end
  end

endmodule
